quadram_burst_master: RTL

Burst initiator that drives the 2048x32 quad-bank scratch RAM port (en / we[3:0] / din / addr / dout) on behalf of the subdivision datapath. It accepts one read or write burst command at a time over valid/ready, streams write data in or read data out, and hides the RAM's one-cycle read latency and its bank-select output mux. It sits between the vertex/face fetch and writeback units and the quadram instance.

---
 rtl/quadram_burst_master.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/quadram_burst_master.sv
// Burst initiator for the 2048x32 quad-bank scratch RAM: one read or write burst at a time,
// hiding the RAM's one-cycle read latency and its bank-selected output mux.
module quadram_burst_master #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [31:0]           rdata,
    output logic                  rdata_last,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_din,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [31:0]           ram_dout
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] DepthW = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StWr, StRd, StBank, StDrain} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_q, cur_d, prev_q, prev_d, next_addr;
    logic [8:0]            rem_q, rem_d;
    logic                  cap_q, cap_d, cap_last_q, cap_last_d, done_q, done_d;
    logic [32:0]           fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]         cnt_q, cnt_d, occ;
    logic [32:0]           head;
    logic                  push, pop;

    assign head        = fifo_mem[rd_ptr_q];
    assign rdata_valid = (cnt_q != '0);
    assign rdata       = rdata_valid ? head[31:0] : 32'h0;
    assign rdata_last  = rdata_valid & head[32];
    assign push        = cap_q;
    assign pop         = rdata_valid & rdata_ready;
    // Reads still in flight count against FIFO space so a capture can never overflow it.
    assign occ         = cnt_q + (PtrW + 1)'(cap_q);
    assign next_addr   = cur_q + ADDR_WIDTH'(1);
    assign busy        = (state_q != StIdle);
    assign done        = done_q;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        prev_d      = prev_q;
        rem_d       = rem_q;
        cap_d       = 1'b0;
        cap_last_d  = 1'b0;
        done_d      = 1'b0;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 4'b0000;
        ram_din     = 32'h0;
        ram_addr    = cur_q;
        unique case (state_q)
            StIdle: begin
                cmd_ready = ~rst;
                if (cmd_valid) begin
                    cur_d   = cmd_addr;
                    rem_d   = {1'b0, cmd_len} + 9'd1;
                    state_d = cmd_write ? StWr : StRd;
                end
            end
            StWr: begin
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    ram_en  = |wstrb;
                    ram_we  = wstrb;
                    ram_din = wdata;
                    cur_d   = next_addr;
                    rem_d   = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StRd: begin
                if (occ < DepthW) begin
                    ram_en = 1'b1;
                    cap_d  = 1'b1;
                    prev_d = cur_q;
                    cur_d  = next_addr;
                    rem_d  = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        cap_last_d = 1'b1;
                        state_d    = StBank;
                    end else if (next_addr[ADDR_WIDTH-1:ADDR_WIDTH-2] !=
                                 cur_q[ADDR_WIDTH-1:ADDR_WIDTH-2]) begin
                        state_d = StBank;
                    end
                end
            end
            StBank: begin
                // Keep the issuing bank on the address bus while its data is captured.
                ram_addr = prev_q;
                state_d  = (rem_q == 9'd0) ? StDrain : StRd;
            end
            StDrain: begin
                ram_addr = prev_q;
                if (pop && head[32]) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_q      <= '0;
            prev_q     <= '0;
            rem_q      <= '0;
            cap_q      <= 1'b0;
            cap_last_q <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            prev_q     <= prev_d;
            rem_q      <= rem_d;
            cap_q      <= cap_d;
            cap_last_q <= cap_last_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cap_last_q, ram_dout};
        end
    end
endmodule
